// File: rtl/sync_fifo_reader_pkg.sv
// Shared defaults and the pop-admission helper for the sync_fifo read adapter.
package sync_fifo_reader_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CNT_WIDTH = 16;

    // A pop is safe when the words held plus in flight, less the one leaving, leave room for one more.
    function automatic logic room_for_pop(input logic [1:0] cnt, input logic pend, input logic deq);
        logic [2:0] occ;
        occ = {1'b0, cnt} + {2'b00, pend} - {2'b00, deq};
        return (occ <= 3'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO-side and stream-side signals of the reader; slave is the reader, master is its surroundings.
interface sync_fifo_reader_if
    import sync_fifo_reader_pkg::*;
#(
    parameter int width = DEF_WIDTH
);
    logic             fifo_empty;
    logic             fifo_pop;
    logic [width-1:0] fifo_rd_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_data;

    modport slave (
        input  fifo_empty, fifo_rd_data, flush, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport master (
        output fifo_empty, fifo_rd_data, flush, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Read-side adapter for sync_fifo: hides the one-cycle read latency behind a two-entry
// buffer and presents a valid/ready stream that sustains one word per cycle.
module sync_fifo_reader
    import sync_fifo_reader_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int cnt_width = DEF_CNT_WIDTH
)(
    input  logic                 clk,
    input  logic                 reset_n,
    sync_fifo_reader_if.slave    bus,
    output logic [cnt_width-1:0] word_count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

    occ_e                 r_cnt, w_cnt_nxt;
    logic                 r_pend;
    logic                 r_head, w_head_nxt;
    logic [width-1:0]     r_buf [2];
    logic [cnt_width-1:0] r_word_count;
    logic                 w_deq;
    logic                 w_pop;
    logic                 w_wr_idx;

    assign w_deq = (r_cnt != EMPTY) && bus.out_ready;

    // Gated by reset_n so the FIFO is never popped while this block is held in reset.
    assign w_pop = reset_n && !bus.fifo_empty && !bus.flush && room_for_pop(r_cnt, r_pend, w_deq);

    // Tail slot sits cnt entries past the head; a same-cycle deq frees the head slot for reuse.
    assign w_wr_idx = r_head ^ r_cnt[0];

    assign bus.fifo_pop  = w_pop;
    assign bus.out_valid = (r_cnt != EMPTY);
    assign bus.out_data  = r_buf[r_head];
    assign word_count    = r_word_count;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_head_nxt = r_head ^ w_deq;
        if (bus.flush) begin
            w_cnt_nxt  = EMPTY;
            w_head_nxt = 1'b0;
        end else begin
            case (r_cnt)
                EMPTY: if (r_pend) w_cnt_nxt = ONE;
                ONE: begin
                    if (r_pend && !w_deq)      w_cnt_nxt = TWO;
                    else if (!r_pend && w_deq) w_cnt_nxt = EMPTY;
                end
                TWO:     if (!r_pend && w_deq) w_cnt_nxt = ONE;
                default: w_cnt_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= EMPTY;
            r_head       <= 1'b0;
            r_pend       <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_head <= w_head_nxt;
            r_pend <= w_pop;
            if (w_deq) r_word_count <= r_word_count + cnt_width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (r_pend && !bus.flush) begin
            r_buf[w_wr_idx] <= bus.fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader driven by a behavioural sync_fifo with registered empty and read data.
module tb_sync_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] wc;
    logic [3:0]  wc4;

    sync_fifo_reader_if #(.width(8)) bus ();
    sync_fifo_reader_if #(.width(8)) bus4 ();

    sync_fifo_reader #(.width(8), .cnt_width(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .word_count(wc));

    // Narrow-counter twin sharing every input, used for the wrap check.
    sync_fifo_reader #(.width(8), .cnt_width(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4), .word_count(wc4));

    logic       rnd_mode = 1'b0;
    logic       rnd_empty = 1'b1;
    logic [7:0] rnd_d = 8'h00;
    logic [7:0] fq [$];
    logic       f_empty = 1'b1;
    logic [7:0] f_rd = 8'h00;

    assign bus.fifo_empty    = rnd_mode ? rnd_empty : f_empty;
    assign bus.fifo_rd_data  = rnd_mode ? rnd_d : f_rd;
    assign bus4.fifo_empty   = bus.fifo_empty;
    assign bus4.fifo_rd_data = bus.fifo_rd_data;
    assign bus4.flush        = bus.flush;
    assign bus4.out_ready    = bus.out_ready;

    always @(posedge clk) begin
        if (bus.fifo_pop && fq.size() > 0) f_rd <= fq.pop_front();
        f_empty <= (fq.size() == 0);
    end

    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got [$];
    int         got_cyc [$];
    int         pop_cnt = 0;
    int         occ_max = 0;
    int         ovf = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                got_cyc.push_back(cyc);
            end
            if (bus.fifo_pop) pop_cnt <= pop_cnt + 1;
            if (int'(dut.r_cnt) > occ_max) occ_max <= int'(dut.r_cnt);
            if (int'(dut.r_cnt) == 2 && dut.r_pend && !(bus.out_valid && bus.out_ready)) ovf <= ovf + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fq.delete();
        nxt(2);
        reset_n = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        int         t_e;
        int         p0;
        int         nerr;
        logic [7:0] rexp [1000];

        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rnd_mode      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt(1);
            rnd_empty     = 1'($urandom_range(0, 1));
            rnd_d         = 8'($urandom);
            bus.flush     = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_pop", 32'(bus.fifo_pop), 0);
            chk("rst_valid", 32'(bus.out_valid), 0);
            chk("rst_data", 32'(bus.out_data), 0);
            chk("rst_wc", 32'(wc), 0);
        end
        nxt(1);
        rnd_mode      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_pop", 32'(bus.fifo_pop), 0);
            chk("idle_valid", 32'(bus.out_valid), 0);
        end

        // Streaming: first word two cycles after empty falls, then back to back.
        nxt(1);
        got.delete();
        got_cyc.delete();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        t_e = cyc + 1;
        nxt(14);
        chk("strm_n", 32'(got.size()), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk("strm_data", 32'(got[i]), 32'(i + 1));
            chk("strm_cyc", 32'(got_cyc[i] - t_e), 32'(i + 2));
        end
        chk("strm_wc", 32'(wc), 8);

        for (int i = 9; i <= 17; i++) fq.push_back(8'(i));
        nxt(16);
        chk("wrap_wc4", 32'(wc4), 1);
        chk("wrap_wc", 32'(wc), 17);

        // Backpressure: only two pops land while the consumer stalls.
        do_reset();
        bus.out_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        nxt(4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 32'h01);
        end
        nxt(1);
        chk("bp_pops", 32'(pop_cnt - p0), 2);
        bus.out_ready = 1'b1;
        nxt(15);
        chk("bp_n", 32'(got.size()), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk("bp_data_out", 32'(got[i]), 32'(i + 1));
            chk("bp_gap", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
        end
        chk("bp_wc", 32'(wc), 8);

        // Random consumer readiness over 1000 words.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            rexp[i] = 8'($urandom);
            fq.push_back(rexp[i]);
        end
        for (int k = 0; k < 6000 && got.size() < 1000; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            nxt(1);
        end
        bus.out_ready = 1'b0;
        nxt(1);
        chk("rnd_n", 32'(got.size()), 1000);
        nerr = 0;
        for (int i = 0; i < 1000 && i < got.size(); i++) if (got[i] !== rexp[i]) nerr++;
        chk("rnd_order", 32'(nerr), 0);
        chk("rnd_wc", 32'(wc), 1000);

        // Flush with one word buffered and one in flight; the flush-cycle deq still counts.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 8'h10; i <= 8'h13; i++) fq.push_back(8'(i));
        nxt(5);
        @(negedge clk);
        chk("fl_pre_data", 32'(bus.out_data), 32'h10);
        nxt(1);
        bus.out_ready = 1'b1;
        nxt(1);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_pend", 32'(dut.r_pend), 1);
        chk("fl_pop", 32'(bus.fifo_pop), 0);
        chk("fl_data", 32'(bus.out_data), 32'h11);
        nxt(1);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("fl_valid", 32'(bus.out_valid), 0);
        chk("fl_wc", 32'(wc), 2);
        chk("fl_pop_resume", 32'(bus.fifo_pop), 1);
        nxt(1);
        bus.out_ready = 1'b1;
        nxt(8);
        chk("fl_n", 32'(got.size()), 3);
        if (got.size() >= 3) begin
            chk("fl_w0", 32'(got[0]), 32'h10);
            chk("fl_w1", 32'(got[1]), 32'h11);
            chk("fl_w2", 32'(got[2]), 32'h13);
        end
        chk("fl_wc_end", 32'(wc), 3);

        chk("occ_le2", 32'(occ_max <= 2), 1);
        chk("no_ovf", 32'(ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
